// File: rtl/count_sequencer_if.sv
// Control/status bundle between the bus logic and the count sequencer.
interface count_sequencer_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 4
);
  logic               start;
  logic               stop;
  logic               hold;
  logic               auto_reload;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   count;
  logic               busy;
  logic               done;
  logic [7:0]         wraps;

  // Control side: drives commands, observes counter status.
  modport master (
    output start, stop, hold, auto_reload, limit, presc,
    input  count, busy, done, wraps
  );

  // Sequencer side: receives commands, drives counter status.
  modport slave (
    input  start, stop, hold, auto_reload, limit, presc,
    output count, busy, done, wraps
  );
endinterface

// File: rtl/count_sequencer.sv
// Run controller for the up-counter: start/hold/stop sequencing, one-shot or
// auto-reload terminal handling, done pulse and saturating wrap tally.
// Optional tick prescaler built only when COUNT_SEQ_PRESCALE_EN is defined.
module count_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  count_sequencer_if.slave bus
);

  localparam int unsigned WRAPS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   limit_q;
  logic               mode_q;
  logic               busy_q;
  logic               done_q;
  logic [WRAPS_W-1:0] wraps_q;

  logic stop_c;
  logic arm_c;
  logic adv_c;
  logic tick_c;

  // Decoded per-cycle actions; stop outranks start, start outranks hold.
  assign stop_c = bus.stop && (state != IDLE);
  assign arm_c  = !bus.stop && bus.start && ((state == IDLE) || (state == DONE));
  assign adv_c  = !bus.stop && !bus.hold && (state == RUN);

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt;

  assign tick_c = (presc_cnt == presc_q);

  // Prescaler: cleared on start/stop, frozen outside active RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      presc_cnt <= '0;
    end else if (arm_c) begin
      presc_q   <= bus.presc;
      presc_cnt <= '0;
    end else if (stop_c) begin
      presc_cnt <= '0;
    end else if (adv_c) begin
      presc_cnt <= tick_c ? '0 : presc_cnt + PRESC_W'(1);
    end
  end
`else
  logic [PRESC_W-1:0] unused_presc;

  assign unused_presc = bus.presc;
  assign tick_c       = 1'b1;
`endif

  // Sequencer FSM with registered count, busy, done and wrap tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop_c) begin
        state   <= IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else if (arm_c) begin
        state   <= RUN;
        limit_q <= bus.limit;
        mode_q  <= bus.auto_reload;
        count_q <= '0;
        wraps_q <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            count_q <= '0;
          end
          RUN: begin
            if (bus.hold) begin
              state <= HOLD;
            end else if (tick_c) begin
              if (count_q != limit_q) begin
                count_q <= count_q + WIDTH'(1);
              end else if (mode_q) begin
                count_q <= '0;
                done_q  <= 1'b1;
                if (wraps_q != {WRAPS_W{1'b1}}) begin
                  wraps_q <= wraps_q + WRAPS_W'(1);
                end
              end else begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= DONE;
              end
            end
          end
          HOLD: begin
            if (!bus.hold) begin
              state <= RUN;
            end
          end
          DONE: begin
            count_q <= limit_q;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wraps = wraps_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus pushes expected outputs per
// edge, an independent monitor pops and compares after each rising edge.
module tb_count_sequencer;

  logic clk;
  logic rst_n;

  count_sequencer_if #(.WIDTH(4), .PRESC_W(4)) bus ();

  count_sequencer #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] c;
    logic       b;
    logic       d;
    logic [7:0] w;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] c, input logic b,
                       input logic d, input logic [7:0] w);
    total++;
    if (bus.count !== c || bus.busy !== b || bus.done !== d || bus.wraps !== w) begin
      bad++;
      $display("FAIL %s @cyc %0d: got count=%0d busy=%0b done=%0b wraps=%0d, want count=%0d busy=%0b done=%0b wraps=%0d",
               nm, cyc, bus.count, bus.busy, bus.done, bus.wraps, c, b, d, w);
    end
  endtask

  // Monitor: compares DUT outputs against expectations due at this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check(e.nm, e.c, e.b, e.d, e.w);
      end
    end
  end

  // Drive inputs for the next rising edge.
  task automatic cyc_step(input logic st, input logic sp, input logic hd);
    @(negedge clk);
    bus.start = st;
    bus.stop  = sp;
    bus.hold  = hd;
  endtask

  // Expected outputs after the upcoming rising edge.
  task automatic push_exp(input string nm, input logic [3:0] c, input logic b,
                          input logic d, input logic [7:0] w);
    exp_t e;
    e.cyc = cyc + 1;
    e.nm  = nm;
    e.c   = c;
    e.b   = b;
    e.d   = d;
    e.w   = w;
    q.push_back(e);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.hold        = 1'b0;
    bus.auto_reload = 1'b0;
    bus.limit       = 4'd0;
    bus.presc       = 4'd0;

    // Reset state
    #2;
    check("reset", 4'd0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 5; i++) begin
      cyc_step(1'b0, 1'b0, 1'b0);
      push_exp("idle", 4'd0, 1'b0, 1'b0, 8'd0);
    end

    // One-shot, limit 5
    bus.limit = 4'd5; bus.auto_reload = 1'b0;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("os_start", 4'd0, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc_step(1'b0, 1'b0, 1'b0); push_exp("os_count", 4'(i), 1'b1, 1'b0, 8'd0);
    end
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("os_done", 4'd5, 1'b0, 1'b1, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("os_keep1", 4'd5, 1'b0, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("os_keep2", 4'd5, 1'b0, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b1, 1'b0); push_exp("os_stop", 4'd0, 1'b0, 1'b0, 8'd0);

    // Auto-reload, limit 3, 20 edges: done every 4th edge
    bus.limit = 4'd3; bus.auto_reload = 1'b1;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("ar_start", 4'd0, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 20; i++) begin
      cyc_step(1'b0, 1'b0, 1'b0);
      push_exp("ar_run", 4'(i % 4), 1'b1, (i % 4) == 0, 8'(i / 4));
    end
    cyc_step(1'b0, 1'b1, 1'b0); push_exp("ar_stop_keep_wraps", 4'd0, 1'b0, 1'b0, 8'd5);

    // Auto-reload, limit 0: done every edge, wraps saturate at 255
    bus.limit = 4'd0; bus.auto_reload = 1'b1;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("sat_start", 4'd0, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 300; i++) begin
      cyc_step(1'b0, 1'b0, 1'b0);
      push_exp("sat_run", 4'd0, 1'b1, 1'b1, (i > 255) ? 8'd255 : 8'(i));
    end
    // Start while busy with a new limit: ignored
    bus.limit = 4'd7;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("busy_start_ign", 4'd0, 1'b1, 1'b1, 8'd255);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("busy_start_ign2", 4'd0, 1'b1, 1'b1, 8'd255);
    cyc_step(1'b0, 1'b1, 1'b0); push_exp("sat_stop", 4'd0, 1'b0, 1'b0, 8'd255);

    // Hold at count 2 for 4 edges, release, then stop+start together
    bus.limit = 4'd9; bus.auto_reload = 1'b0;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("hd_start", 4'd0, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("hd_c1", 4'd1, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("hd_c2", 4'd2, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      cyc_step(1'b0, 1'b0, 1'b1); push_exp("hd_frozen", 4'd2, 1'b1, 1'b0, 8'd0);
    end
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("hd_release", 4'd2, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("hd_resume", 4'd3, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b1, 1'b1, 1'b0); push_exp("stop_beats_start", 4'd0, 1'b0, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("hd_idle", 4'd0, 1'b0, 1'b0, 8'd0);

    // One-shot, limit 0: done on first tick; re-arm from DONE
    bus.limit = 4'd0; bus.auto_reload = 1'b0;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("os0_start", 4'd0, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("os0_done", 4'd0, 1'b0, 1'b1, 8'd0);
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("os0_rearm", 4'd0, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("os0_done2", 4'd0, 1'b0, 1'b1, 8'd0);
    cyc_step(1'b0, 1'b1, 1'b0); push_exp("os0_stop", 4'd0, 1'b0, 1'b0, 8'd0);

    // Stop on a terminal-tick edge suppresses done
    bus.limit = 4'd2; bus.auto_reload = 1'b1;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("sup_start", 4'd0, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("sup_c1", 4'd1, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("sup_c2", 4'd2, 1'b1, 1'b0, 8'd0);
    cyc_step(1'b0, 1'b1, 1'b0); push_exp("sup_stop", 4'd0, 1'b0, 1'b0, 8'd0);

    // Prescale 2, limit 1, auto-reload
    bus.limit = 4'd1; bus.auto_reload = 1'b1; bus.presc = 4'd2;
    cyc_step(1'b1, 1'b0, 1'b0); push_exp("ps_start", 4'd0, 1'b1, 1'b0, 8'd0);
`ifdef COUNT_SEQ_PRESCALE_EN
    for (int i = 1; i <= 12; i++) begin
      cyc_step(1'b0, 1'b0, 1'b0);
      push_exp("ps_run", 4'((i / 3) % 2), 1'b1, (i % 6) == 0, 8'(i / 6));
    end
`else
    for (int i = 1; i <= 12; i++) begin
      cyc_step(1'b0, 1'b0, 1'b0);
      push_exp("ps_ignored", 4'(i % 2), 1'b1, (i % 2) == 0, 8'(i / 2));
    end
`endif
    cyc_step(1'b0, 1'b0, 1'b0);
`ifdef COUNT_SEQ_PRESCALE_EN
    push_exp("ps_run13", 4'd0, 1'b1, 1'b0, 8'd2);
`else
    push_exp("ps_ignored13", 4'd1, 1'b1, 1'b0, 8'd6);
`endif

    // Asynchronous reset mid-run clears outputs without a clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.presc = 4'd0;
    cyc_step(1'b0, 1'b0, 1'b0); push_exp("post_reset_idle", 4'd0, 1'b0, 1'b0, 8'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
